spi_slave_sync: RTL and testbench

Single-clock SPI slave responder that oversamples the master's `sclk`, `cs_n` and `mosi` in the system clock domain, so it can be used without a separate serial-clock domain. It implements all four SPI modes, transfers 8-bit frames MSB first, and supports back-to-back bytes within one chip-select window. It sits on the slave side of the serial bus, facing an SPI master. It exposes a buffered transmit-load handshake and a one-cycle receive strobe to local logic.

---
 rtl/spi_slave_sync_if.sv | 26 ++
 rtl/spi_slave_sync.sv | 163 ++++++++++++++++
 tb/tb_spi_slave_sync.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_sync_if.sv
// Bus bundle between an SPI master with its local byte handshake and spi_slave_sync.
// The slave modport is the responder view; the master modport drives pins and tx loads.
interface spi_slave_sync_if;
    logic [1:0] mode;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    modport slave (
        input  mode, cs_n, sclk, mosi, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output mode, cs_n, sclk, mosi, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave_sync.sv
// Oversampling SPI slave: sclk/cs_n/mosi are synchronized into clk, 8-bit MSB-first
// frames in all four modes, back-to-back bytes, buffered transmit holding register.
module spi_slave_sync (
    input  logic            i_clk,
    input  logic            i_reset,
    spi_slave_sync_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_XFER} state_t;

    state_t     r_state;
    logic       r_sclkMeta, r_sclkSync, r_sclkDly;
    logic       r_csMeta, r_csSync, r_csDly;
    logic       r_mosiMeta, r_mosiSync;
    logic       r_cpol, r_cpha;
    logic [2:0] r_bitCnt;
    logic [6:0] r_rxShift;
    logic [7:0] r_txShift;
    logic [7:0] r_hold;
    logic       r_txReady;
    logic       r_reloadPend;
    logic       r_miso;
    logic [7:0] r_rxData;
    logic       r_rxValid;
    logic       r_txUnderrun;
    logic       r_busy;

    logic       w_sclkRise, w_sclkFall, w_csFall;
    logic       w_leadEdge, w_trailEdge, w_sampleEdge, w_shiftEdge;
    logic       w_inXfer, w_lastSample, w_reload, w_accept;
    logic [7:0] w_reloadByte, w_rxByte, w_cpha1Src;

    assign w_sclkRise   = r_sclkSync & ~r_sclkDly;
    assign w_sclkFall   = ~r_sclkSync & r_sclkDly;
    assign w_csFall     = ~r_csSync & r_csDly;
    assign w_leadEdge   = r_cpol ? w_sclkFall : w_sclkRise;
    assign w_trailEdge  = r_cpol ? w_sclkRise : w_sclkFall;
    assign w_sampleEdge = r_cpha ? w_trailEdge : w_leadEdge;
    assign w_shiftEdge  = r_cpha ? w_leadEdge : w_trailEdge;

    // A level check on cs_n keeps the frame from surviving a release that lands during LOAD.
    assign w_inXfer     = (r_state == S_XFER) && !r_csSync;
    assign w_lastSample = w_inXfer && w_sampleEdge && (r_bitCnt == 3'd7);
    assign w_reload     = (r_state == S_LOAD)
                        || (w_lastSample && !r_cpha)
                        || (w_inXfer && w_shiftEdge && r_cpha && r_reloadPend);
    assign w_reloadByte = r_txReady ? 8'h00 : r_hold;
    assign w_rxByte     = {r_rxShift, r_mosiSync};
    assign w_cpha1Src   = r_reloadPend ? w_reloadByte : r_txShift;
    assign w_accept     = bus.tx_load && r_txReady;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_sclkMeta   <= 1'b0;
            r_sclkSync   <= 1'b0;
            r_sclkDly    <= 1'b0;
            r_csMeta     <= 1'b1;
            r_csSync     <= 1'b1;
            r_csDly      <= 1'b1;
            r_mosiMeta   <= 1'b0;
            r_mosiSync   <= 1'b0;
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_bitCnt     <= 3'd0;
            r_rxShift    <= 7'd0;
            r_txShift    <= 8'h00;
            r_hold       <= 8'h00;
            r_txReady    <= 1'b1;
            r_reloadPend <= 1'b0;
            r_miso       <= 1'b0;
            r_rxData     <= 8'h00;
            r_rxValid    <= 1'b0;
            r_txUnderrun <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sclkMeta   <= bus.sclk;
            r_sclkSync   <= r_sclkMeta;
            r_sclkDly    <= r_sclkSync;
            r_csMeta     <= bus.cs_n;
            r_csSync     <= r_csMeta;
            r_csDly      <= r_csSync;
            r_mosiMeta   <= bus.mosi;
            r_mosiSync   <= r_mosiMeta;
            r_rxValid    <= 1'b0;
            r_txUnderrun <= 1'b0;

            // A reload reads the old holding content; a same-cycle accepted load refills it.
            if (w_reload) begin
                r_txReady    <= 1'b1;
                r_txUnderrun <= r_txReady;
            end
            if (w_accept) begin
                r_hold    <= bus.tx_data;
                r_txReady <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_miso <= 1'b0;
                    r_busy <= 1'b0;
                    if (w_csFall) begin
                        r_cpol  <= bus.mode[1];
                        r_cpha  <= bus.mode[0];
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_txShift    <= w_reloadByte;
                    r_bitCnt     <= 3'd0;
                    r_reloadPend <= 1'b0;
                    r_miso       <= r_cpha ? 1'b0 : w_reloadByte[7];
                    r_state      <= S_XFER;
                end

                S_XFER: begin
                    if (r_csSync) begin
                        r_miso       <= 1'b0;
                        r_busy       <= 1'b0;
                        r_bitCnt     <= 3'd0;
                        r_reloadPend <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (w_sampleEdge) begin
                        r_rxShift <= w_rxByte[6:0];
                        r_bitCnt  <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_rxData  <= w_rxByte;
                            r_rxValid <= 1'b1;
                            if (r_cpha) begin
                                r_reloadPend <= 1'b1;
                            end else begin
                                r_txShift <= w_reloadByte;
                                r_miso    <= w_reloadByte[7];
                            end
                        end
                    end else if (w_shiftEdge) begin
                        // CPHA=0 skips the shift after the 8th sample since the reload already placed the new MSB.
                        if (r_cpha) begin
                            r_miso       <= w_cpha1Src[7];
                            r_txShift    <= {w_cpha1Src[6:0], 1'b0};
                            r_reloadPend <= 1'b0;
                        end else if (r_bitCnt != 3'd0) begin
                            r_miso    <= r_txShift[6];
                            r_txShift <= {r_txShift[6:0], 1'b0};
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.miso        = r_miso;
    assign bus.tx_ready    = r_txReady;
    assign bus.rx_data     = r_rxData;
    assign bus.rx_valid    = r_rxValid;
    assign bus.tx_underrun = r_txUnderrun;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a bit-banged SPI master drives frames in all modes
// and compares received bytes and handshake strobes against hand-computed values.
module tb_spi_slave_sync;
    localparam int halfCycles = 4;

    logic clk = 1'b0;
    logic reset;

    spi_slave_sync_if bus();

    spi_slave_sync dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int         checkCount = 0;
    int         errorCount = 0;
    int         cycleCount = 0;
    int         underrunCount = 0;
    int         rxWide = 0;
    int         underrunWide = 0;
    logic       rxPrev = 1'b0;
    logic       underrunPrev = 1'b0;
    logic [7:0] rxLog[$];
    int         rxCycleLog[$];

    always @(negedge clk) begin
        cycleCount   <= cycleCount + 1;
        rxPrev       <= bus.rx_valid;
        underrunPrev <= bus.tx_underrun;
        if (bus.rx_valid === 1'b1) begin
            rxLog.push_back(bus.rx_data);
            rxCycleLog.push_back(cycleCount);
            if (rxPrev === 1'b1) rxWide <= rxWide + 1;
        end
        if (bus.tx_underrun === 1'b1) begin
            underrunCount <= underrunCount + 1;
            if (underrunPrev === 1'b1) underrunWide <= underrunWide + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadTx(input logic [7:0] data);
        int waitCycles;
        waitCycles = 0;
        @(negedge clk);
        while (bus.tx_ready !== 1'b1 && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("txReadyBeforeLoad", 32'(bus.tx_ready), 32'd1);
        bus.tx_data = data;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    // One chip-select window of numBits bits; mosi bits come from mosiBits[15] downward.
    task automatic applyStimulus(input logic [1:0] frameMode, input int numBits,
                                 input logic [15:0] mosiBits, output logic [15:0] misoBits);
        logic cpol;
        logic cpha;
        cpol     = frameMode[1];
        cpha     = frameMode[0];
        misoBits = 16'h0000;
        @(negedge clk);
        bus.mode = frameMode;
        bus.sclk = cpol;
        bus.mosi = 1'b0;
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < numBits; i++) begin
            if (!cpha) begin
                bus.mosi = mosiBits[15 - i];
                repeat (halfCycles) @(negedge clk);
                misoBits = {misoBits[14:0], bus.miso};
                bus.sclk = ~cpol;
                repeat (halfCycles) @(negedge clk);
                bus.sclk = cpol;
            end else begin
                bus.sclk = ~cpol;
                bus.mosi = mosiBits[15 - i];
                repeat (halfCycles) @(negedge clk);
                misoBits = {misoBits[14:0], bus.miso};
                bus.sclk = cpol;
                repeat (halfCycles) @(negedge clk);
            end
        end
        repeat (halfCycles) @(negedge clk);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        logic [15:0] misoBits;
        int          urBefore;
        logic [7:0]  logVal0;
        logic [7:0]  logVal1;
        int          gap;

        reset       = 1'b1;
        bus.mode    = 2'd0;
        bus.cs_n    = 1'b1;
        bus.sclk    = 1'b0;
        bus.mosi    = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_load = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstMiso", 32'(bus.miso), 32'd0);
        checkOutput("rstRxData", 32'(bus.rx_data), 32'h00);
        checkOutput("rstRxValid", 32'(bus.rx_valid), 32'd0);
        checkOutput("rstUnderrun", 32'(bus.tx_underrun), 32'd0);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstTxReady", 32'(bus.tx_ready), 32'd1);

        $display("[TB] mode 0 single byte");
        loadTx(8'hA5);
        checkOutput("m0TxHeld", 32'(bus.tx_ready), 32'd0);
        rxLog.delete();
        fork
            applyStimulus(2'd0, 8, {8'h3C, 8'h00}, misoBits);
            begin
                repeat (14) @(negedge clk);
                checkOutput("m0Busy", 32'(bus.busy), 32'd1);
                checkOutput("m0TxReadyAfterLoad", 32'(bus.tx_ready), 32'd1);
            end
        join
        checkOutput("m0MisoByte", 32'(misoBits[7:0]), 32'hA5);
        checkOutput("m0RxData", 32'(bus.rx_data), 32'h3C);
        checkOutput("m0RxPulses", 32'(rxLog.size()), 32'd1);
        checkOutput("m0MisoDeselected", 32'(bus.miso), 32'd0);

        $display("[TB] abort after 5 bits");
        rxLog.delete();
        applyStimulus(2'd0, 5, {8'hFF, 8'h00}, misoBits);
        checkOutput("abortRxPulses", 32'(rxLog.size()), 32'd0);
        checkOutput("abortRxKept", 32'(bus.rx_data), 32'h3C);
        checkOutput("abortBusy", 32'(bus.busy), 32'd0);
        applyStimulus(2'd0, 8, {8'h5A, 8'h00}, misoBits);
        checkOutput("afterAbortRxData", 32'(bus.rx_data), 32'h5A);
        checkOutput("afterAbortRxPulses", 32'(rxLog.size()), 32'd1);

        $display("[TB] modes 1 to 3");
        for (int m = 1; m < 4; m++) begin
            loadTx(8'h81);
            checkOutput($sformatf("m%0dMisoIdle", m), 32'(bus.miso), 32'd0);
            rxLog.delete();
            applyStimulus(2'(m), 8, {8'h7E, 8'h00}, misoBits);
            checkOutput($sformatf("m%0dMisoByte", m), 32'(misoBits[7:0]), 32'h81);
            checkOutput($sformatf("m%0dRxData", m), 32'(bus.rx_data), 32'h7E);
            checkOutput($sformatf("m%0dRxPulses", m), 32'(rxLog.size()), 32'd1);
            checkOutput($sformatf("m%0dMisoAfter", m), 32'(bus.miso), 32'd0);
        end

        $display("[TB] back-to-back bytes");
        loadTx(8'h11);
        rxLog.delete();
        rxCycleLog.delete();
        fork
            applyStimulus(2'd0, 16, {8'hB7, 8'h4D}, misoBits);
            begin
                repeat (30) @(negedge clk);
                loadTx(8'h22);
            end
        join
        checkOutput("b2bMiso", 32'(misoBits), 32'h1122);
        checkOutput("b2bRxPulses", 32'(rxLog.size()), 32'd2);
        logVal0 = (rxLog.size() > 0) ? rxLog[0] : 8'h00;
        logVal1 = (rxLog.size() > 1) ? rxLog[1] : 8'h00;
        gap     = (rxCycleLog.size() > 1) ? (rxCycleLog[1] - rxCycleLog[0]) : 0;
        checkOutput("b2bRxByte0", 32'(logVal0), 32'hB7);
        checkOutput("b2bRxByte1", 32'(logVal1), 32'h4D);
        checkOutput("b2bGapAtLeast8", 32'(gap >= 8), 32'd1);

        $display("[TB] underrun");
        urBefore = underrunCount;
        rxLog.delete();
        applyStimulus(2'd1, 16, {8'h12, 8'h34}, misoBits);
        checkOutput("urMiso", 32'(misoBits), 32'h0000);
        checkOutput("urPulses", 32'(underrunCount - urBefore), 32'd2);
        checkOutput("urRxPulses", 32'(rxLog.size()), 32'd2);
        checkOutput("urRxData", 32'(bus.rx_data), 32'h34);

        $display("[TB] reset mid-byte");
        loadTx(8'h44);
        @(negedge clk);
        bus.mode = 2'd0;
        bus.sclk = 1'b0;
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (8) @(negedge clk);
        loadTx(8'h99);
        checkOutput("rstHeld", 32'(bus.tx_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.mosi = 1'b1;
            repeat (halfCycles) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (halfCycles) @(negedge clk);
            bus.sclk = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midRstTxReady", 32'(bus.tx_ready), 32'd1);
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        checkOutput("midRstMiso", 32'(bus.miso), 32'd0);
        checkOutput("midRstRxValid", 32'(bus.rx_valid), 32'd0);
        checkOutput("midRstRxData", 32'(bus.rx_data), 32'h00);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("postRstTxReady", 32'(bus.tx_ready), 32'd1);
        checkOutput("postRstBusy", 32'(bus.busy), 32'd0);
        urBefore = underrunCount;
        applyStimulus(2'd3, 8, {8'h96, 8'h00}, misoBits);
        checkOutput("postRstMisoByte", 32'(misoBits[7:0]), 32'h00);
        checkOutput("postRstUnderrun", 32'(underrunCount - urBefore), 32'd1);
        checkOutput("postRstRxData", 32'(bus.rx_data), 32'h96);

        checkOutput("rxValidWidth", 32'(rxWide), 32'd0);
        checkOutput("underrunWidth", 32'(underrunWide), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
